// File: rtl/sprite_rom_arbiter.sv
// rtl/sprite_rom_arbiter.sv - round-robin burst arbiter sharing one single-port sprite ROM
//
// Purpose:
//    Grants one of N_REQ pixel requesters at a time, streams its burst of consecutive ROM
//    addresses one per clock, and tags returning ROM data with the owning requester id and
//    an end-of-burst flag. Back-to-back bursts keep the address stream free of bubbles.
//
// Ports:
//    i_Clk         system clock
//    i_Reset       synchronous reset, active-high
//    i_Req         per-requester request level
//    i_Start_Addr  packed burst start addresses, requester n at [n*ADDR_W +: ADDR_W]
//    i_Len         packed burst lengths, requester n at [n*LEN_W +: LEN_W] (0 acts as 1)
//    o_Ack         one-hot accept strobe (combinational, only in IDLE)
//    o_Rom_Addr    registered ROM address
//    i_Rom_Data    ROM read data, ROM_LATENCY clocks after o_Rom_Addr
//    o_Data        registered pixel data
//    o_Valid       o_Data valid this cycle
//    o_Id          requester owning o_Data
//    o_Last        o_Data is the last pixel of its burst
//    o_Busy        FSM is in BURST
module sprite_rom_arbiter #(
   parameter int N_REQ       = 4,
   parameter int ADDR_W      = 10,
   parameter int DATA_W      = 9,
   parameter int LEN_W       = 6,
   parameter int ROM_LATENCY = 1
) (
   input  logic                     i_Clk,
   input  logic                     i_Reset,
   input  logic [N_REQ-1:0]         i_Req,
   input  logic [N_REQ*ADDR_W-1:0]  i_Start_Addr,
   input  logic [N_REQ*LEN_W-1:0]   i_Len,
   output logic [N_REQ-1:0]         o_Ack,
   output logic [ADDR_W-1:0]        o_Rom_Addr,
   input  logic [DATA_W-1:0]        i_Rom_Data,
   output logic [DATA_W-1:0]        o_Data,
   output logic                     o_Valid,
   output logic [$clog2(N_REQ)-1:0] o_Id,
   output logic                     o_Last,
   output logic                     o_Busy
);

   localparam int ID_W = $clog2(N_REQ);

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t            state;
   state_t            state_next;

   logic [ID_W-1:0]   ptr;
   logic [ID_W-1:0]   cur_id;
   logic [LEN_W-1:0]  remaining;
   logic [LEN_W-1:0]  remaining_next;

   logic              grant_valid;
   logic [ID_W-1:0]   grant_id;
   logic [ADDR_W-1:0] grant_start;
   logic [LEN_W-1:0]  grant_len;
   logic [LEN_W-1:0]  len_eff;

   logic              issue;
   logic              issue_last;
   logic [ID_W-1:0]   issue_id;
   logic [ADDR_W-1:0] addr_next;

   // Stage 0 is aligned with o_Rom_Addr; the ROM adds ROM_LATENCY more stages before data
   // appears on i_Rom_Data, so the tag read at index ROM_LATENCY lines up with i_Rom_Data.
   logic [ROM_LATENCY:0] tag_valid;
   logic [ROM_LATENCY:0] tag_last;
   logic [ID_W-1:0]      tag_id [ROM_LATENCY+1];

   // Round-robin search starting just above the last granted requester.
   always_comb begin : arbitrate
      int idx;
      idx         = 0;
      grant_valid = 1'b0;
      grant_id    = '0;
      grant_start = '0;
      grant_len   = '0;
      o_Ack       = '0;
      if (state == IDLE && !i_Reset) begin
         for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!grant_valid && i_Req[idx]) begin
               grant_valid = 1'b1;
               grant_id    = ID_W'(idx);
               grant_start = i_Start_Addr[idx*ADDR_W +: ADDR_W];
               grant_len   = i_Len[idx*LEN_W +: LEN_W];
            end
         end
      end
      if (grant_valid) begin
         o_Ack[grant_id] = 1'b1;
      end
   end

   always_comb begin : next_state
      state_next     = state;
      issue          = 1'b0;
      issue_last     = 1'b0;
      issue_id       = cur_id;
      addr_next      = o_Rom_Addr;
      remaining_next = remaining;
      // A zero length field is treated as a single-pixel burst.
      len_eff        = (grant_len == '0) ? LEN_W'(1) : grant_len;
      case (state)
         IDLE: begin
            if (grant_valid) begin
               issue          = 1'b1;
               issue_id       = grant_id;
               addr_next      = grant_start;
               issue_last     = (len_eff == LEN_W'(1));
               remaining_next = len_eff - LEN_W'(1);
               if (!issue_last) begin
                  state_next = BURST;
               end
            end
         end
         BURST: begin
            issue          = 1'b1;
            addr_next      = o_Rom_Addr + ADDR_W'(1);
            issue_last     = (remaining == LEN_W'(1));
            remaining_next = remaining - LEN_W'(1);
            if (issue_last) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_Clk) begin : state_reg
      if (i_Reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge i_Clk) begin : datapath
      if (i_Reset) begin
         ptr        <= ID_W'(N_REQ - 1);
         cur_id     <= '0;
         remaining  <= '0;
         o_Rom_Addr <= '0;
         tag_valid  <= '0;
         tag_last   <= '0;
         for (int i = 0; i <= ROM_LATENCY; i++) begin
            tag_id[i] <= '0;
         end
         o_Data     <= '0;
         o_Valid    <= 1'b0;
         o_Id       <= '0;
         o_Last     <= 1'b0;
      end else begin
         o_Rom_Addr <= addr_next;
         remaining  <= remaining_next;
         if (state == IDLE && grant_valid) begin
            ptr    <= grant_id;
            cur_id <= grant_id;
         end
         tag_valid <= {tag_valid[ROM_LATENCY-1:0], issue};
         tag_last  <= {tag_last[ROM_LATENCY-1:0], issue_last};
         tag_id[0] <= issue_id;
         for (int i = 1; i <= ROM_LATENCY; i++) begin
            tag_id[i] <= tag_id[i-1];
         end
         o_Data  <= i_Rom_Data;
         o_Valid <= tag_valid[ROM_LATENCY];
         o_Id    <= tag_id[ROM_LATENCY];
         o_Last  <= tag_last[ROM_LATENCY];
      end
   end

   assign o_Busy = (state == BURST);

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb/tb_sprite_rom_arbiter.sv - randomized self-checking bench for sprite_rom_arbiter
module tb_sprite_rom_arbiter;

   localparam int N    = 4;
   localparam int AW   = 10;
   localparam int DW   = 9;
   localparam int LW   = 6;
   localparam int MAXC = 8192;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [N-1:0]      req = '0;
   logic [N*AW-1:0]   start = '0;
   logic [N*LW-1:0]   len = '0;
   logic [N-1:0]      ack;
   logic [AW-1:0]     rom_addr;
   logic [DW-1:0]     rom_data;
   logic [DW-1:0]     data;
   logic              valid;
   logic [1:0]        id;
   logic              last;
   logic              busy;

   sprite_rom_arbiter #(
      .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .ROM_LATENCY(1)
   ) dut (
      .i_Clk(clk), .i_Reset(rst), .i_Req(req), .i_Start_Addr(start), .i_Len(len),
      .o_Ack(ack), .o_Rom_Addr(rom_addr), .i_Rom_Data(rom_data), .o_Data(data),
      .o_Valid(valid), .o_Id(id), .o_Last(last), .o_Busy(busy)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] mem [1024];
   always @(posedge clk) rom_data <= mem[rom_addr];

   typedef struct {
      int id;
      int start;
      int len;
   } burst_t;

   burst_t pend[$];

   // Reference model: per-cycle schedule of expected ROM address and output pixels.
   bit exp_v   [MAXC];
   int exp_id  [MAXC];
   bit exp_lst [MAXC];
   int exp_a   [MAXC];
   bit ra_set  [MAXC];
   int ra_val  [MAXC];
   int cyc     = 0;
   int free_c  = 0;
   int last_id = N - 1;
   int cur_ra  = 0;

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic int first_of(input int n);
      for (int i = 0; i < pend.size(); i++) begin
         if (pend[i].id == n) return i;
      end
      return -1;
   endfunction

   task automatic push(input int n, input int s, input int l);
      burst_t b;
      b.id = n; b.start = s; b.len = l;
      pend.push_back(b);
   endtask

   task automatic step(input bit r);
      int idx;
      int w;
      int l;
      logic [N-1:0] exp_ack;
      @(posedge clk);
      #1;
      rst   = r;
      req   = '0;
      start = '0;
      len   = '0;
      for (int n = 0; n < N; n++) begin
         idx = first_of(n);
         if (idx >= 0) begin
            req[n]            = 1'b1;
            start[n*AW +: AW] = AW'(pend[idx].start);
            len[n*LW +: LW]   = LW'(pend[idx].len);
         end
      end
      @(negedge clk);
      if (ra_set[cyc]) cur_ra = ra_val[cyc];
      exp_ack = '0;
      if (cyc >= 1) begin
         check_eq("rom_addr", 32'(rom_addr), 32'(cur_ra));
         check_eq("busy", 32'(busy), 32'(cyc < free_c));
         check_eq("valid", 32'(valid), 32'(exp_v[cyc]));
         if (exp_v[cyc]) begin
            check_eq("id", 32'(id), 32'(exp_id[cyc]));
            check_eq("last", 32'(last), 32'(exp_lst[cyc]));
            check_eq("data", 32'(data), 32'(mem[exp_a[cyc]]));
         end
      end
      if (r) begin
         for (int t = cyc + 1; t < MAXC; t++) begin
            exp_v[t]  = 1'b0;
            ra_set[t] = 1'b0;
         end
         ra_set[cyc+1] = 1'b1;
         ra_val[cyc+1] = 0;
         free_c        = cyc + 1;
         last_id       = N - 1;
      end else if (cyc >= free_c && req != '0) begin
         w = -1;
         for (int k = 1; k <= N; k++) begin
            if (w < 0 && req[(last_id + k) % N]) w = (last_id + k) % N;
         end
         idx = first_of(w);
         l   = (pend[idx].len == 0) ? 1 : pend[idx].len;
         for (int j = 0; j < l; j++) begin
            ra_set[cyc+1+j]  = 1'b1;
            ra_val[cyc+1+j]  = (pend[idx].start + j) % 1024;
            exp_v[cyc+3+j]   = 1'b1;
            exp_id[cyc+3+j]  = w;
            exp_lst[cyc+3+j] = (j == l - 1);
            exp_a[cyc+3+j]   = (pend[idx].start + j) % 1024;
         end
         exp_ack[w] = 1'b1;
         free_c     = cyc + l;
         last_id    = w;
         pend.delete(idx);
      end
      check_eq("ack", 32'(ack), 32'(exp_ack));
      cyc++;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = DW'($urandom);

      step(1'b1);
      step(1'b1);
      repeat (3) step(1'b0);

      push(2, 'h010, 4);
      repeat (8) step(1'b0);

      push(0, int'($urandom_range(0, 1023)), 2);
      push(1, int'($urandom_range(0, 1023)), 2);
      repeat (8) step(1'b0);

      for (int r = 0; r < 2; r++) begin
         for (int n = 0; n < N; n++) push(n, int'($urandom_range(0, 1023)), 1);
      end
      repeat (14) step(1'b0);

      push(1, 'h3FE, 4);
      repeat (8) step(1'b0);

      push(0, int'($urandom_range(0, 1023)), 8);
      repeat (3) step(1'b0);
      step(1'b1);
      repeat (6) step(1'b0);
      push(3, int'($urandom_range(0, 1023)), 1);
      repeat (5) step(1'b0);

      push(1, int'($urandom_range(0, 1023)), 0);
      repeat (5) step(1'b0);

      for (int c = 0; c < 1500; c++) begin
         for (int n = 0; n < N; n++) begin
            if (first_of(n) < 0 && $urandom_range(0, 3) == 0) begin
               if ($urandom_range(0, 3) == 0)
                  push(n, int'($urandom_range(0, 1023)), int'($urandom_range(0, 3)));
               else
                  push(n, int'($urandom_range(0, 1023)), int'($urandom_range(0, 40)));
            end
         end
         step($urandom_range(0, 399) == 0);
      end

      for (int i = 0; i < 800 && pend.size() > 0; i++) step(1'b0);
      check_eq("drain", 32'(pend.size()), 32'(0));
      repeat (70) step(1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
